// File: rtl/reg_dump_tx_pkg.sv
// Shared definitions for the register-dump transmitter: datapath widths,
// UART framing constants, the dump FSM state type and a frame builder.
package reg_dump_tx_pkg;

    // Register-file geometry (16-bit data, 8 registers addressed by 3 bits).
    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    // UART 8N1: start bit, 8 data bits, stop bit.
    localparam int         UART_FRAME_BITS    = 10;
    localparam logic [7:0] REG_DUMP_SYNC_BYTE = 8'hA5;

    // Dump sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_SEND_HI,
        ST_SEND_LO,
        ST_NEXT,
        ST_FIN
    } dump_state_t;

    // Build a frame in transmit order: bit 0 goes on the line first.
    function automatic logic [UART_FRAME_BITS-1:0] uart_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/reg_dump_tx_uart_tx_byte.sv
// uart_tx_byte: single-frame UART 8N1 transmitter.
// A byte is accepted with LOAD while READY=1. READY also rises in the last
// cycle of the stop bit, so a LOAD there starts the next frame with no gap.
module uart_tx_byte
    import reg_dump_tx_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       LOAD,
    input  logic [7:0] DATA,
    output logic       TXD,
    output logic       READY
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic                       active;
    logic [BAUD_W-1:0]          baud_cnt;
    logic [3:0]                 bit_cnt;
    logic [UART_FRAME_BITS-1:0] shreg;
    logic                       txd_q;
    logic [UART_FRAME_BITS-1:0] frame;

    assign frame = uart_frame(DATA);
    assign READY = !active || ((bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST));
    assign TXD   = txd_q;

    // Baud/bit counters and shift register; counters only move while a frame is active.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; it is just the highest-priority branch under the clock edge.
        if (!RST_N) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '1;
            txd_q    <= 1'b1;
        end else if (LOAD && READY) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= frame;
            txd_q    <= frame[0];
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    active  <= 1'b0;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {1'b1, shreg[UART_FRAME_BITS-1:1]};
                    txd_q   <= shreg[1];
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// reg_dump_tx: on START, reads registers 0..NUM_REGS-1 through the register
// file's third read port and streams each as two UART frames (high byte first).
// Build option: define REG_DUMP_SYNC_EN to prefix the dump with one 0xA5 frame.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int CLK_DIV  = 434,
    parameter int NUM_REGS = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic [REG_W-1:0]  RD_REG,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              TXD,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

    dump_state_t       state;
    dump_state_t       state_nxt;
    logic [REG_W-1:0]  rd_reg;
    logic [DATA_W-1:0] shadow;
    logic              busy;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              done;

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (tx_load),
        .DATA  (tx_data),
        .TXD   (TXD),
        .READY (tx_ready)
    );

    assign RD_REG = rd_reg;
    assign BUSY   = busy;
    assign DONE   = done;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register index, snapshot of the register being sent, and the BUSY flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_reg <= '0;
            shadow <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        rd_reg <= '0;
                        busy   <= 1'b1;
                    end
                end
                ST_LOAD: shadow <= RD_DATA;
                ST_NEXT: begin
                    if (rd_reg != LAST_REG) begin
                        rd_reg <= rd_reg + 1'b1;
                    end
                end
                ST_FIN: begin
                    busy   <= 1'b0;
                    rd_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. LOAD and NEXT run while the previous low byte is still
    // on the line, so the following high byte is ready when the stop bit ends.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
`ifdef REG_DUMP_SYNC_EN
                    state_nxt = ST_SYNC;
`else
                    state_nxt = ST_LOAD;
`endif
                end
            end
            // The transmitter is always idle in IDLE, so the sync byte is taken at once.
            ST_SYNC: state_nxt = ST_LOAD;
            // When the line is already free (first register, no sync frame) the high
            // byte goes straight from RD_DATA and SEND_HI has nothing left to wait for.
            ST_LOAD: state_nxt = tx_ready ? ST_SEND_LO : ST_SEND_HI;
            ST_SEND_HI: begin
                if (tx_ready) state_nxt = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                if (tx_ready) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (rd_reg != LAST_REG) begin
                    state_nxt = ST_LOAD;
                end else if (tx_ready) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: transmitter hand-off and the DONE pulse.
    always_comb begin
        tx_load = 1'b0;
        tx_data = shadow[15:8];
        done    = 1'b0;
        case (state)
            ST_SYNC: begin
                tx_load = 1'b1;
                tx_data = REG_DUMP_SYNC_BYTE;
            end
            ST_LOAD: begin
                tx_load = tx_ready;
                tx_data = RD_DATA[15:8];
            end
            ST_SEND_HI: begin
                tx_load = tx_ready;
                tx_data = shadow[15:8];
            end
            ST_SEND_LO: begin
                tx_load = tx_ready;
                tx_data = shadow[7:0];
            end
            ST_FIN:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Testbench for reg_dump_tx: behavioural register file, UART receiver monitor
// and a byte scoreboard fed from the register contents at START time.
module tb_reg_dump_tx;

    localparam int CLK_DIV   = 4;
    localparam int NUM_REGS  = 8;
    localparam int FRAME_CYC = 10 * CLK_DIV;
`ifdef REG_DUMP_SYNC_EN
    localparam int N_FRAMES = 2 * NUM_REGS + 1;
`else
    localparam int N_FRAMES = 2 * NUM_REGS;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rd_reg;
    logic [15:0] rd_data;
    logic        txd;
    logic        busy;
    logic        done;

    logic [15:0] regs [NUM_REGS];

    always #5 clk = ~clk;

    assign rd_data = regs[rd_reg];

    reg_dump_tx #(
        .CLK_DIV  (CLK_DIV),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .START   (start),
        .RD_REG  (rd_reg),
        .RD_DATA (rd_data),
        .TXD     (txd),
        .BUSY    (busy),
        .DONE    (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Free-running cycle count; cycle n is the interval after the n-th posedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DONE pulses and BUSY-high cycles, sampled mid-cycle.
    int done_cnt = 0;
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Scoreboard of bytes the host should receive, in order.
    logic [7:0] exp_q [$];
    int         frame_cycles [$];
    int         rx_count = 0;

    // UART receiver: one sample per cycle; every bit must hold for CLK_DIV samples.
    initial begin : monitor
        logic [9:0] bits;
        logic       shape_ok;
        logic       aborted;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst_n && (txd == 1'b0)) begin
                frame_cycles.push_back(cyc);
                bits     = '0;
                shape_ok = 1'b1;
                aborted  = 1'b0;
                for (int s = 0; s < FRAME_CYC; s++) begin
                    if (s > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if ((s % CLK_DIV) == 0) bits[s / CLK_DIV] = txd;
                    else if (txd !== bits[s / CLK_DIV]) shape_ok = 1'b0;
                end
                if (!aborted) begin
                    rx_count++;
                    check("frame_shape(ok,start,stop)", {29'd0, shape_ok, bits[0], bits[9]}, 32'b101);
                    check("byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        check("rx_byte", bits[8:1], exp_b);
                    end
                end
            end
        end
    end

    // Model of one dump: optional sync byte, then each register high byte first.
    task automatic expect_dump();
`ifdef REG_DUMP_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        for (int r = 0; r < NUM_REGS; r++) begin
            exp_q.push_back(regs[r][15:8]);
            exp_q.push_back(regs[r][7:0]);
        end
    endtask

    task automatic randomize_regs();
        for (int r = 0; r < NUM_REGS; r++) regs[r] = 16'($urandom);
    endtask

    // START high for exactly one cycle; s is the cycle in which it is sampled.
    task automatic pulse_start(output int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        s     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Full dump with optional second START at cycle offset extra_at (0 = none).
    task automatic full_dump(input string tag, input int extra_at);
        int   s;
        int   rx0, d0, b0, f0;
        logic ok;
        rx0 = rx_count;
        d0  = done_cnt;
        b0  = busy_cnt;
        f0  = frame_cycles.size();
        expect_dump();
        pulse_start(s);
        if (extra_at > 0) begin
            while (cyc < s + extra_at) begin
                @(posedge clk);
                #1;
            end
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(N_FRAMES * FRAME_CYC + 100, ok);
        check({tag, "_done_seen"}, ok, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_cycles"}, busy_cnt - b0, 2 + N_FRAMES * FRAME_CYC);
        check({tag, "_frames"}, rx_count - rx0, N_FRAMES);
        check({tag, "_leftover"}, exp_q.size(), 0);
        check({tag, "_frame_starts"}, frame_cycles.size() - f0, N_FRAMES);
        if (frame_cycles.size() > f0) begin
            check({tag, "_first_start_latency"}, frame_cycles[f0] - s, 2);
            check({tag, "_gapless_span"}, frame_cycles[$] - frame_cycles[f0], (N_FRAMES - 1) * FRAME_CYC);
        end
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_rd_reg_after"}, rd_reg, 0);
        check({tag, "_txd_after"}, txd, 1);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   s, rx0, f1, viol_txd, viol_busy, viol_done;
        for (int r = 0; r < NUM_REGS; r++) regs[r] = '0;

        // Reset and idle hold.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_txd", txd, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_reg", rd_reg, 0);
        viol_txd  = 0;
        viol_busy = 0;
        viol_done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) viol_txd++;
            if (busy !== 1'b0) viol_busy++;
            if (done !== 1'b0) viol_done++;
        end
        check("idle_txd_low_cycles", viol_txd, 0);
        check("idle_busy_cycles", viol_busy, 0);
        check("idle_done_cycles", viol_done, 0);

        // Fixed pattern: register n holds 0xnnnn.
        for (int r = 0; r < NUM_REGS; r++) regs[r] = 16'(r * 16'h1111);
        full_dump("pattern", 0);

        // Random contents with a second START in the middle of frame 5.
        randomize_regs();
        full_dump("restart_ignored", 2 + 4 * FRAME_CYC + 10);

        // Reset during frame 3, bit 4.
        randomize_regs();
        rx0 = rx_count;
        expect_dump();
        pulse_start(s);
        while (cyc < s + 2 + 2 * FRAME_CYC + 4 * CLK_DIV + 1) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_txd", txd, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_reg", rd_reg, 0);
        check("midrst_frames_before", rx_count - rx0, 2);
        exp_q.delete();
        f1 = frame_cycles.size();
        repeat (3 * FRAME_CYC) @(negedge clk);
        check("midrst_line_quiet", frame_cycles.size() - f1, 0);
        check("midrst_no_done", done_cnt > 0 && done, 0);

        randomize_regs();
        full_dump("after_reset", 0);

        randomize_regs();
        full_dump("random", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
